// File: rtl/xadc_multichannel_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xadc_multichannel_packetizer
// Purpose  : Joins N 16-bit sample channels into one framed, tagged byte stream.
//            Optional sequence-number trailer: XADC_PACKETIZER_SEQ_NUM_EN
// Revision : 1.0 - initial release
// ============================================================================
module xadc_multichannel_packetizer #(
   parameter int         NUM_CHANNELS = 2,
   parameter int         SAMPLE_WIDTH = 12,
   parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [16*NUM_CHANNELS-1:0] s_tdata,
   input  logic [NUM_CHANNELS-1:0]   s_tvalid,
   output logic [NUM_CHANNELS-1:0]   s_tready,
   output logic [7:0]                m_tdata,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic                      m_tlast,
   output logic                      busy
);

`ifdef XADC_PACKETIZER_SEQ_NUM_EN
   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      SEND_HEADER = 3'd1,
      SEND_UPPER  = 3'd2,
      SEND_LOWER  = 3'd3,
      SEND_SEQ    = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      SEND_HEADER = 3'd1,
      SEND_UPPER  = 3'd2,
      SEND_LOWER  = 3'd3
   } state_t;
`endif

   localparam logic [3:0] LAST_CH = 4'(NUM_CHANNELS - 1);

   state_t      state_q, state_d;
   logic [3:0]  ch_q, ch_d;
   logic [7:0]  tdata_q, tdata_d;
   logic        tvalid_q, tvalid_d;
   logic        tlast_q, tlast_d;
   logic        busy_q, busy_d;
   logic [15:0] words_q [NUM_CHANNELS];
`ifdef XADC_PACKETIZER_SEQ_NUM_EN
   logic [7:0]  seq_q, seq_d;
`endif

   logic [15:0] w_cap [NUM_CHANNELS];
   logic [15:0] w_cur_word;
   logic [15:0] w_next_word;
   logic        w_join;
   logic        w_out_hs;
   logic        w_unused_sdata;

   // Only the low SAMPLE_WIDTH bits of each lane matter; the rest are dropped.
   assign w_unused_sdata = ^s_tdata;

   assign w_join   = (state_q == IDLE) & (&s_tvalid) & ~rst;
   assign w_out_hs = tvalid_q & m_tready;
   assign s_tready = {NUM_CHANNELS{w_join}};

   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_cap
         assign w_cap[gi] = {4'(gi), 12'(s_tdata[16*gi +: SAMPLE_WIDTH])};
      end
   endgenerate

   always_comb begin
      w_cur_word  = '0;
      w_next_word = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (4'(c) == ch_q)         w_cur_word  = words_q[c];
         if (4'(c) == ch_q + 4'd1)  w_next_word = words_q[c];
      end
   end

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
`ifdef XADC_PACKETIZER_SEQ_NUM_EN
      seq_d    = seq_q;
`endif
      case (state_q)
         IDLE: begin
            if (w_join) begin
               state_d  = SEND_HEADER;
               tdata_d  = HEADER_BYTE;
               tvalid_d = 1'b1;
               tlast_d  = 1'b0;
            end
         end
         SEND_HEADER: begin
            if (w_out_hs) begin
               state_d = SEND_UPPER;
               ch_d    = 4'd0;
               tdata_d = words_q[0][15:8];
            end
         end
         SEND_UPPER: begin
            if (w_out_hs) begin
               state_d = SEND_LOWER;
               tdata_d = w_cur_word[7:0];
`ifndef XADC_PACKETIZER_SEQ_NUM_EN
               tlast_d = (ch_q == LAST_CH);
`endif
            end
         end
         SEND_LOWER: begin
            if (w_out_hs) begin
               if (ch_q < LAST_CH) begin
                  state_d = SEND_UPPER;
                  ch_d    = ch_q + 4'd1;
                  tdata_d = w_next_word[15:8];
               end else begin
`ifdef XADC_PACKETIZER_SEQ_NUM_EN
                  state_d = SEND_SEQ;
                  tdata_d = seq_q;
                  tlast_d = 1'b1;
`else
                  state_d  = IDLE;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
`endif
               end
            end
         end
`ifdef XADC_PACKETIZER_SEQ_NUM_EN
         SEND_SEQ: begin
            if (w_out_hs) begin
               state_d  = IDLE;
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               seq_d    = seq_q + 8'd1;
            end
         end
`endif
         default: begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ch_q     <= 4'd0;
         tdata_q  <= 8'd0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
         for (int c = 0; c < NUM_CHANNELS; c++) words_q[c] <= 16'd0;
`ifdef XADC_PACKETIZER_SEQ_NUM_EN
         seq_q    <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         busy_q   <= busy_d;
         if (w_join) words_q <= w_cap;
`ifdef XADC_PACKETIZER_SEQ_NUM_EN
         seq_q    <= seq_d;
`endif
      end
   end

   assign m_tdata  = tdata_q;
   assign m_tvalid = tvalid_q;
   assign m_tlast  = tlast_q;
   assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_xadc_multichannel_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xadc_multichannel_packetizer
// Purpose  : Scoreboard bench for the packetizer (2- and 4-channel instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xadc_multichannel_packetizer;

`ifdef XADC_PACKETIZER_SEQ_NUM_EN
   localparam int SEQ = 1;
`else
   localparam int SEQ = 0;
`endif
   localparam int FL2 = 1 + 2*2 + SEQ;
   localparam int FL4 = 1 + 2*4 + SEQ;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] s_tdata2  = '0;
   logic [1:0]  s_tvalid2 = '0;
   logic [1:0]  s_tready2;
   logic [7:0]  m_tdata2;
   logic        m_tvalid2, m_tlast2, busy2;
   logic        m_tready2 = 1'b1;

   logic [63:0] s_tdata4  = '0;
   logic [3:0]  s_tvalid4 = '0;
   logic [3:0]  s_tready4;
   logic [7:0]  m_tdata4;
   logic        m_tvalid4, m_tlast4, busy4;
   logic        m_tready4 = 1'b1;

   xadc_multichannel_packetizer #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(12), .HEADER_BYTE(8'hA5)) dut2 (
      .clk(clk), .rst(rst), .s_tdata(s_tdata2), .s_tvalid(s_tvalid2), .s_tready(s_tready2),
      .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tready(m_tready2), .m_tlast(m_tlast2), .busy(busy2));

   xadc_multichannel_packetizer #(.NUM_CHANNELS(4), .SAMPLE_WIDTH(12), .HEADER_BYTE(8'hA5)) dut4 (
      .clk(clk), .rst(rst), .s_tdata(s_tdata4), .s_tvalid(s_tvalid4), .s_tready(s_tready4),
      .m_tdata(m_tdata4), .m_tvalid(m_tvalid4), .m_tready(m_tready4), .m_tlast(m_tlast4), .busy(busy4));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int bytes2 = 0, frames2 = 0, sready2 = 0, flen2 = 0;
   int bytes4 = 0, frames4 = 0, flen4 = 0;
   logic [8:0] q2 [$];
   logic [8:0] q4 [$];
   logic [7:0] exp_seq2 = 8'd0;
   logic [7:0] exp_seq4 = 8'd0;
   logic       hold2 = 1'b0, hold4 = 1'b0;
   logic [7:0] hd2, hd4;
   logic       hl2, hl4;
   logic [8:0] e2, e4;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitors: one byte popped per output handshake, stall hold checked.
   always @(negedge clk) begin
      if (rst) begin
         hold2 = 1'b0;
         flen2 = 0;
      end else begin
         if (hold2) begin
            n_checks++;
            if (m_tvalid2 !== 1'b1 || m_tdata2 !== hd2 || m_tlast2 !== hl2) begin
               n_fail++;
               $display("FAIL stall_hold2: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                        m_tvalid2, m_tdata2, m_tlast2, hd2, hl2);
            end
         end
         if (s_tready2 === 2'b11) sready2++;
         if (m_tvalid2 === 1'b1 && m_tready2 === 1'b1) begin
            n_checks++;
            if (q2.size() == 0) begin
               n_fail++;
               $display("FAIL byte2: got d=%h l=%b, required no byte", m_tdata2, m_tlast2);
            end else begin
               e2 = q2.pop_front();
               if ({m_tlast2, m_tdata2} !== e2) begin
                  n_fail++;
                  $display("FAIL byte2: got d=%h l=%b, required d=%h l=%b",
                           m_tdata2, m_tlast2, e2[7:0], e2[8]);
               end
            end
            bytes2++;
            flen2++;
            if (m_tlast2 === 1'b1) begin
               frames2++;
               n_checks++;
               if (flen2 != FL2) begin
                  n_fail++;
                  $display("FAIL frame_len2: got %0d, required %0d", flen2, FL2);
               end
               flen2 = 0;
            end
         end
         hold2 = (m_tvalid2 === 1'b1) && (m_tready2 !== 1'b1);
         hd2   = m_tdata2;
         hl2   = m_tlast2;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         hold4 = 1'b0;
         flen4 = 0;
      end else begin
         if (hold4) begin
            n_checks++;
            if (m_tvalid4 !== 1'b1 || m_tdata4 !== hd4 || m_tlast4 !== hl4) begin
               n_fail++;
               $display("FAIL stall_hold4: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                        m_tvalid4, m_tdata4, m_tlast4, hd4, hl4);
            end
         end
         if (m_tvalid4 === 1'b1 && m_tready4 === 1'b1) begin
            n_checks++;
            if (q4.size() == 0) begin
               n_fail++;
               $display("FAIL byte4: got d=%h l=%b, required no byte", m_tdata4, m_tlast4);
            end else begin
               e4 = q4.pop_front();
               if ({m_tlast4, m_tdata4} !== e4) begin
                  n_fail++;
                  $display("FAIL byte4: got d=%h l=%b, required d=%h l=%b",
                           m_tdata4, m_tlast4, e4[7:0], e4[8]);
               end
            end
            bytes4++;
            flen4++;
            if (m_tlast4 === 1'b1) begin
               frames4++;
               n_checks++;
               if (flen4 != FL4) begin
                  n_fail++;
                  $display("FAIL frame_len4: got %0d, required %0d", flen4, FL4);
               end
               flen4 = 0;
            end
         end
         hold4 = (m_tvalid4 === 1'b1) && (m_tready4 !== 1'b1);
         hd4   = m_tdata4;
         hl4   = m_tlast4;
      end
   end

   // Drives one join on dut2 (dsel=0) or dut4 (dsel=1) and pushes the expected
   // frame (first npush bytes, or all when npush<0). Entered/left at posedge+1.
   task automatic send_frame(input int dsel, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3,
                             input int npush, output int waited);
      logic [15:0] d [4];
      logic [15:0] w;
      logic [8:0]  b [$];
      int          n;
      logic        got;
      d = '{d0, d1, d2, d3};
      n = (dsel == 0) ? 2 : 4;
      b.push_back({1'b0, 8'hA5});
      for (int c = 0; c < n; c++) begin
         w = {4'(c), d[c][11:0]};
         b.push_back({1'b0, w[15:8]});
         b.push_back({(SEQ == 0) && (c == n - 1), w[7:0]});
      end
      if (SEQ != 0) b.push_back({1'b1, (dsel == 0) ? exp_seq2 : exp_seq4});
      if (dsel == 0) begin
         s_tdata2  = {d1, d0};
         s_tvalid2 = 2'b11;
      end else begin
         s_tdata4  = {d3, d2, d1, d0};
         s_tvalid4 = 4'hF;
      end
      waited = 0;
      got    = 1'b0;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         if ((dsel == 0 && s_tready2 === 2'b11) || (dsel != 0 && s_tready4 === 4'hF)) begin
            got = 1'b1;
            break;
         end
         waited++;
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL join_timeout: got no s_tready after %0d cycles, required a join", waited);
      end else begin
         for (int i = 0; i < b.size(); i++) begin
            if (npush < 0 || i < npush) begin
               if (dsel == 0) q2.push_back(b[i]);
               else           q4.push_back(b[i]);
            end
         end
         if (npush < 0) begin
            if (dsel == 0) exp_seq2 = exp_seq2 + 8'd1;
            else           exp_seq4 = exp_seq4 + 8'd1;
         end
      end
      @(posedge clk);
      #1;
      s_tvalid2 = 2'b00;
      s_tvalid4 = 4'h0;
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (busy2 === 1'b0 && busy4 === 1'b0 && m_tvalid2 === 1'b0 && m_tvalid4 === 1'b0) begin
            done = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL idle_timeout: got busy2=%b busy4=%b, required both idle", busy2, busy4);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      s_tvalid2 = 2'b11;
      s_tvalid4 = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (s_tready2 !== 2'b00) begin n_fail++; $display("FAIL rst_s_tready2: got %b, required 00", s_tready2); end
      n_checks++;
      if (m_tvalid2 !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid2: got %b, required 0", m_tvalid2); end
      n_checks++;
      if (m_tlast2 !== 1'b0) begin n_fail++; $display("FAIL rst_m_tlast2: got %b, required 0", m_tlast2); end
      n_checks++;
      if (m_tdata2 !== 8'h00) begin n_fail++; $display("FAIL rst_m_tdata2: got %h, required 00", m_tdata2); end
      n_checks++;
      if (busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_busy2: got %b, required 0", busy2); end
      n_checks++;
      if ({s_tready4, m_tvalid4, m_tlast4, busy4, m_tdata4} !== 15'd0) begin
         n_fail++;
         $display("FAIL rst_dut4: got rdy=%b v=%b l=%b b=%b d=%h, required all 0",
                  s_tready4, m_tvalid4, m_tlast4, busy4, m_tdata4);
      end
      s_tvalid2 = 2'b00;
      s_tvalid4 = 4'h0;
      rst       = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (s_tready2 !== 2'b00 || m_tvalid2 !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_rst: got rdy=%b v=%b, required 00/0", s_tready2, m_tvalid2);
      end
   endtask

   task automatic test_basic();
      int w, sr0;
      sr0 = sready2;
      send_frame(0, 16'h0ABC, 16'h0123, 16'h0, 16'h0, -1, w);
      n_checks++;
      if (s_tready2 !== 2'b00) begin n_fail++; $display("FAIL basic_ready_drop: got %b, required 00", s_tready2); end
      for (int i = 0; i < FL2; i++) begin
         @(negedge clk);
         n_checks++;
         if (m_tvalid2 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_consecutive: byte %0d got m_tvalid=%b, required 1", i, m_tvalid2);
         end
      end
      @(negedge clk);
      n_checks++;
      if (m_tvalid2 !== 1'b0 || busy2 !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_end: got v=%b busy=%b, required 0/0", m_tvalid2, busy2);
      end
      n_checks++;
      if (sready2 - sr0 != 1) begin n_fail++; $display("FAIL basic_ready_pulses: got %0d, required 1", sready2 - sr0); end
      n_checks++;
      if (q2.size() != 0) begin n_fail++; $display("FAIL basic_drain: got %0d left, required 0", q2.size()); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_partial();
      int w;
      s_tdata2  = {16'h0C0D, 16'h0FED};
      s_tvalid2 = 2'b01;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (s_tready2 !== 2'b00 || m_tvalid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_hold: cycle %0d got rdy=%b v=%b, required 00/0", i, s_tready2, m_tvalid2);
         end
         @(posedge clk);
         #1;
      end
      send_frame(0, 16'h0FED, 16'h0C0D, 16'h0, 16'h0, -1, w);
      n_checks++;
      if (w != 0) begin n_fail++; $display("FAIL partial_join_delay: got %0d, required 0", w); end
      n_checks++;
      if (m_tvalid2 !== 1'b1 || m_tdata2 !== 8'hA5) begin
         n_fail++;
         $display("FAIL partial_start: got v=%b d=%h, required 1/a5", m_tvalid2, m_tdata2);
      end
      wait_idle();
      n_checks++;
      if (q2.size() != 0) begin n_fail++; $display("FAIL partial_drain: got %0d left, required 0", q2.size()); end
   endtask

   task automatic test_stall();
      int w;
      logic [3:0] pat;
      pat       = 4'b1001;
      m_tready2 = 1'b1;
      send_frame(0, 16'h0555, 16'h07FF, 16'h0, 16'h0, -1, w);
      for (int i = 0; i < 24; i++) begin
         m_tready2 = pat[3 - (i % 4)];
         @(posedge clk);
         #1;
      end
      m_tready2 = 1'b1;
      wait_idle();
      n_checks++;
      if (q2.size() != 0) begin n_fail++; $display("FAIL stall_drain: got %0d left, required 0", q2.size()); end
   endtask

   task automatic test_four_channels();
      int w, b0;
      b0 = bytes4;
      send_frame(1, 16'h0111, 16'h0222, 16'h0333, 16'hFFFF, -1, w);
      wait_idle();
      n_checks++;
      if (bytes4 - b0 != FL4) begin n_fail++; $display("FAIL four_len: got %0d, required %0d", bytes4 - b0, FL4); end
      n_checks++;
      if (q4.size() != 0) begin n_fail++; $display("FAIL four_drain: got %0d left, required 0", q4.size()); end
   endtask

   task automatic test_reset_mid();
      int w;
      m_tready2 = 1'b1;
      send_frame(0, 16'h0ABC, 16'h0123, 16'h0, 16'h0, 3, w);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (m_tdata2 !== 8'h11 || m_tlast2 !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_position: got d=%h l=%b, required 11/0", m_tdata2, m_tlast2);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (m_tvalid2 !== 1'b0 || m_tlast2 !== 1'b0 || m_tdata2 !== 8'h00 || busy2 !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_abort: got v=%b l=%b d=%h b=%b, required 0/0/00/0",
                  m_tvalid2, m_tlast2, m_tdata2, busy2);
      end
      rst      = 1'b0;
      exp_seq2 = 8'd0;
      exp_seq4 = 8'd0;
      n_checks++;
      if (q2.size() != 0) begin n_fail++; $display("FAIL mid_partial: got %0d left, required 0", q2.size()); end
      send_frame(0, 16'h0ABC, 16'h0123, 16'h0, 16'h0, -1, w);
      n_checks++;
      if (m_tvalid2 !== 1'b1 || m_tdata2 !== 8'hA5) begin
         n_fail++;
         $display("FAIL mid_restart: got v=%b d=%h, required 1/a5", m_tvalid2, m_tdata2);
      end
      wait_idle();
      n_checks++;
      if (q2.size() != 0) begin n_fail++; $display("FAIL mid_drain: got %0d left, required 0", q2.size()); end
   endtask

   task automatic test_back_to_back();
      int w, f0, t0, t1, nf;
      nf = (SEQ != 0) ? 257 : 8;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      exp_seq2 = 8'd0;
      exp_seq4 = 8'd0;
      m_tready2 = 1'b1;
      f0 = frames2;
      send_frame(0, 16'($urandom), 16'($urandom), 16'h0, 16'h0, -1, w);
      t0 = cyc;
      for (int i = 1; i < nf; i++) send_frame(0, 16'($urandom), 16'($urandom), 16'h0, 16'h0, -1, w);
      t1 = cyc;
      n_checks++;
      if (t1 - t0 != (nf - 1) * (FL2 + 1)) begin
         n_fail++;
         $display("FAIL b2b_period: got %0d cycles, required %0d", t1 - t0, (nf - 1) * (FL2 + 1));
      end
      wait_idle();
      n_checks++;
      if (frames2 - f0 != nf) begin n_fail++; $display("FAIL b2b_frames: got %0d, required %0d", frames2 - f0, nf); end
      n_checks++;
      if (q2.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d left, required 0", q2.size()); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_stall();
      test_four_channels();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/xadc_multichannel_packetizer.md
Name: xadc_multichannel_packetizer

Overview:
- Generalised successor to the two-channel XADC sample packetizer. Joins N 16-bit AXI-Stream sample channels from the XADC sequencer FIFOs into one framed 8-bit byte stream.
- Each frame is: header byte, then big-endian 16-bit words, each tagged with its channel index. The last byte carries tlast.
- The output feeds the COBS encoder wrapper directly. This block does no encoding itself.

Parameters:
- NUM_CHANNELS, 2, number of sample input channels; legal range 1..16.
- SAMPLE_WIDTH, 12, valid sample bits per channel, taken from s_tdata LSBs; legal range 1..12.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  shared clock for all inputs and the output.
- rst  in  1  synchronous, active-high reset.
- s_tdata  in  16*NUM_CHANNELS  channel c occupies bits [16c+15:16c].
- s_tvalid  in  NUM_CHANNELS  per-channel valid.
- s_tready  out  NUM_CHANNELS  per-channel ready; all bits are always equal.
- m_tdata  out  8  framed byte stream.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready (COBS encoder).
- m_tlast  out  1  marks the final byte of a frame.
- busy  out  1  high while any state other than IDLE is active.

Behaviour:
- Reset values: s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, state=IDLE, channel index=0, sequence counter=0.
- All outputs except s_tready are registered. s_tready = (state==IDLE) & (&s_tvalid) & !rst, combinational.
- Join rule:
  - Samples are consumed only when every channel is valid in the same cycle. All channels are then consumed together.
  - Partial valid: nothing is consumed and s_tready stays 0.
  - The block never consumes a subset of channels.
- Capture, on the handshake cycle:
  - For each channel c, word[c] = {c[3:0], zero-extended s_tdata[16c +: SAMPLE_WIDTH]}.
  - Bits of s_tdata above SAMPLE_WIDTH are ignored.
  - m_tdata <= HEADER_BYTE and m_tvalid <= 1 on the next edge.
- States:
  - IDLE: waits for the join. On the handshake, captures all words, loads the header, and goes to SEND_HEADER.
  - SEND_HEADER: on m_tvalid&m_tready, loads word[0][15:8] and goes to SEND_UPPER with ch=0.
  - SEND_UPPER: on handshake, loads word[ch][7:0] and goes to SEND_LOWER.
  - SEND_LOWER: on handshake, behaviour depends on the channel:
    - If ch < NUM_CHANNELS-1: ch++, loads word[ch+1][15:8], goes to SEND_UPPER.
    - Otherwise: goes to the trailer path; see Optional Feature.
  - The last byte of a frame is loaded with m_tlast=1. On its handshake: m_tvalid <= 0, m_tlast <= 0, state goes to IDLE.
- Frame length is 1+2*NUM_CHANNELS bytes, plus 1 if SEQ_NUM_EN is defined.
- Output stability: m_tdata, m_tlast and m_tvalid hold while m_tvalid=1 and m_tready=0. m_tvalid never drops without a handshake.
- Throughput: with m_tready held at 1, one byte per cycle. After the last-byte handshake, the next capture happens no earlier than the following cycle (one idle cycle between frames).
- Input backpressure: s_tready=0 for the whole frame. Samples arriving mid-frame wait in the upstream FIFOs.
- Reset mid-frame: the frame is abandoned with no tlast. All outputs return to reset values on the next edge. Captured words are discarded.
- NUM_CHANNELS=1: the frame is header, upper, lower. tlast is on the lower byte (without SEQ_NUM_EN).

Optional Feature:
- Macro: XADC_PACKETIZER_SEQ_NUM_EN.
- Defined:
  - After the final SEND_LOWER handshake, the state moves to SEND_SEQ, which outputs the 8-bit sequence counter with m_tlast=1.
  - The counter increments by 1 on the SEND_SEQ handshake and wraps 8'hFF to 8'h00. It resets to 0.
  - The host uses it to detect dropped frames.
- Undefined:
  - No SEND_SEQ state and no counter logic.
  - tlast is on the final lower byte.

Test Plan:
- NUM_CHANNELS=2, m_tready=1. ch0=16'h0ABC and ch1=16'h0123 valid together. Expected: A5,0A,BC,11,23 (tlast on 23) in 5 consecutive cycles; s_tready pulses once for both channels.
- Only ch0 valid for 10 cycles, then ch1 also valid. Expected: no s_tready and no m_tvalid during the 10 cycles; the frame starts the cycle after the join.
- m_tready toggles 1,0,0,1 through a frame. Expected: m_tdata and m_tlast are stable while stalled, and no byte is duplicated or lost.
- NUM_CHANNELS=4, SAMPLE_WIDTH=12, input ch3=16'hFFFF. Expected: ch3 bytes are 3F,FF; upper bits are masked and tag=3. Frame length 9.
- rst asserted while state is SEND_UPPER of ch1. Expected: m_tvalid=0 next cycle, no tlast emitted; a fresh join produces a full frame starting with A5.
- With SEQ_NUM_EN, send 257 frames. Expected: trailer bytes run 00..FF and then 00, each carrying tlast, and each frame is 6 bytes long.
